// File: rtl/uart_rx_cfg.sv
// Parametrised UART receiver: 2-FF synchroniser, oversampled 3-sample majority vote,
// parity/framing/break/overrun reporting and a one-entry valid/ready output register.
module uart_rx_cfg #(
    parameter int CLK_FREQ   = 50_000_000,
    parameter int BAUD_RATE  = 115200,
    parameter int DATA_BITS  = 8,
    parameter int PARITY     = 0,
    parameter int STOP_BITS  = 1,
    parameter int OVERSAMPLE = 16
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx,
    output logic [DATA_BITS-1:0] data_out,
    output logic                 valid,
    input  logic                 ready,
    output logic                 parity_err,
    output logic                 frame_err,
    output logic                 break_det,
    output logic                 overrun
);
    localparam int DIV   = CLK_FREQ / (BAUD_RATE * OVERSAMPLE);
    localparam int M     = OVERSAMPLE / 2;
    localparam int DIV_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam int S_W   = $clog2(OVERSAMPLE);
    localparam int BC_W  = $clog2(DATA_BITS);

    localparam logic [2:0] ST_IDLE   = 3'd0;
    localparam logic [2:0] ST_START  = 3'd1;
    localparam logic [2:0] ST_DATA   = 3'd2;
    localparam logic [2:0] ST_PARITY = 3'd3;
    localparam logic [2:0] ST_STOP   = 3'd4;
    localparam logic [2:0] ST_BREAK  = 3'd5;

    generate
        if (DIV < 1 || (OVERSAMPLE % 2) != 0 || OVERSAMPLE < 8 ||
            DATA_BITS < 5 || DATA_BITS > 9 || (STOP_BITS != 1 && STOP_BITS != 2) ||
            PARITY < 0 || PARITY > 2) begin : g_bad_params
            $error("uart_rx_cfg: illegal parameter combination");
        end
    endgenerate

    logic                 rx_meta_reg, rxs_reg;
    logic [2:0]           state_reg;
    logic [DIV_W-1:0]     div_cnt_reg;
    logic [S_W-1:0]       samp_cnt_reg;
    logic [BC_W-1:0]      bit_cnt_reg;
    logic                 stop_cnt_reg;
    logic                 samp_a_reg, samp_b_reg;
    logic [DATA_BITS-1:0] shift_reg;
    logic                 par_bit_reg;
    logic                 stop_low_reg, first_stop_low_reg;
    logic [DATA_BITS-1:0] data_out_reg;
    logic                 valid_reg, parity_err_reg, frame_err_reg, break_det_reg, overrun_reg;

    logic tick, at_decide, at_end, vote, last_stop, frame_done;
    logic first_stop_zero, is_break, deliver, load, parity_calc, frame_err_calc, shift_en;

    assign tick      = (div_cnt_reg == DIV_W'(DIV - 1));
    assign at_decide = tick && (samp_cnt_reg == S_W'(M + 1));
    assign at_end    = tick && (samp_cnt_reg == S_W'(OVERSAMPLE - 1));
    assign vote      = (samp_a_reg & samp_b_reg) | (samp_a_reg & rxs_reg) | (samp_b_reg & rxs_reg);
    assign last_stop = (stop_cnt_reg == 1'(STOP_BITS - 1));
    assign shift_en  = (state_reg == ST_DATA) && at_decide;

    // Frame completes at the decision tick of the last stop bit so a back-to-back start can be caught.
    assign frame_done      = (state_reg == ST_STOP) && at_decide && last_stop;
    assign first_stop_zero = (stop_cnt_reg == 1'b0) ? ~vote : first_stop_low_reg;
    assign frame_err_calc  = stop_low_reg | ~vote;
    assign is_break        = frame_done && (shift_reg == '0) &&
                             ((PARITY == 0) || !par_bit_reg) && first_stop_zero;
    assign deliver         = frame_done && !is_break;
    assign load            = deliver && (!valid_reg || ready);

    always_comb begin
        parity_calc = 1'b0;
        if (PARITY == 1)
            parity_calc = ~(^shift_reg ^ par_bit_reg);
        else if (PARITY == 2)
            parity_calc = ^shift_reg ^ par_bit_reg;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rx_meta_reg <= 1'b1;
            rxs_reg     <= 1'b1;
        end else begin
            rx_meta_reg <= rx;
            rxs_reg     <= rx_meta_reg;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < DATA_BITS; gi++) begin : g_shift
            if (gi == DATA_BITS - 1) begin : g_top
                always_ff @(posedge clk) begin
                    if (rst)           shift_reg[gi] <= 1'b0;
                    else if (shift_en) shift_reg[gi] <= vote;
                end
            end else begin : g_mid
                always_ff @(posedge clk) begin
                    if (rst)           shift_reg[gi] <= 1'b0;
                    else if (shift_en) shift_reg[gi] <= shift_reg[gi+1];
                end
            end
        end
    endgenerate

    always_ff @(posedge clk) begin
        if (rst) begin
            state_reg          <= ST_IDLE;
            div_cnt_reg        <= '0;
            samp_cnt_reg       <= '0;
            bit_cnt_reg        <= '0;
            stop_cnt_reg       <= 1'b0;
            samp_a_reg         <= 1'b1;
            samp_b_reg         <= 1'b1;
            par_bit_reg        <= 1'b0;
            stop_low_reg       <= 1'b0;
            first_stop_low_reg <= 1'b0;
        end else begin
            if (state_reg == ST_IDLE || state_reg == ST_BREAK) begin
                div_cnt_reg  <= '0;
                samp_cnt_reg <= '0;
            end else if (tick) begin
                div_cnt_reg  <= '0;
                samp_cnt_reg <= at_end ? '0 : samp_cnt_reg + 1'b1;
            end else begin
                div_cnt_reg <= div_cnt_reg + 1'b1;
            end

            if (tick && samp_cnt_reg == S_W'(M - 1)) samp_a_reg <= rxs_reg;
            if (tick && samp_cnt_reg == S_W'(M))     samp_b_reg <= rxs_reg;

            case (state_reg)
                ST_IDLE: begin
                    bit_cnt_reg        <= '0;
                    stop_cnt_reg       <= 1'b0;
                    stop_low_reg       <= 1'b0;
                    first_stop_low_reg <= 1'b0;
                    if (!rxs_reg) state_reg <= ST_START;
                end
                ST_START: begin
                    if (at_decide && vote) state_reg <= ST_IDLE;
                    else if (at_end)       state_reg <= ST_DATA;
                end
                ST_DATA: begin
                    if (at_end) begin
                        if (bit_cnt_reg == BC_W'(DATA_BITS - 1))
                            state_reg <= (PARITY != 0) ? ST_PARITY : ST_STOP;
                        else
                            bit_cnt_reg <= bit_cnt_reg + 1'b1;
                    end
                end
                ST_PARITY: begin
                    if (at_decide) par_bit_reg <= vote;
                    if (at_end)    state_reg   <= ST_STOP;
                end
                ST_STOP: begin
                    if (at_decide) begin
                        if (last_stop) begin
                            state_reg <= is_break ? ST_BREAK : ST_IDLE;
                        end else begin
                            first_stop_low_reg <= ~vote;
                            stop_low_reg       <= stop_low_reg | ~vote;
                        end
                    end
                    if (at_end) stop_cnt_reg <= stop_cnt_reg + 1'b1;
                end
                ST_BREAK: begin
                    if (rxs_reg) state_reg <= ST_IDLE;
                end
                default: state_reg <= ST_IDLE;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            data_out_reg   <= '0;
            valid_reg      <= 1'b0;
            parity_err_reg <= 1'b0;
            frame_err_reg  <= 1'b0;
            break_det_reg  <= 1'b0;
            overrun_reg    <= 1'b0;
        end else begin
            break_det_reg <= is_break;
            overrun_reg   <= deliver && valid_reg && !ready;
            if (load) begin
                data_out_reg   <= shift_reg;
                parity_err_reg <= parity_calc;
                frame_err_reg  <= frame_err_calc;
                valid_reg      <= 1'b1;
            end else if (valid_reg && ready) begin
                valid_reg <= 1'b0;
            end
        end
    end

    assign data_out   = data_out_reg;
    assign valid      = valid_reg;
    assign parity_err = parity_err_reg;
    assign frame_err  = frame_err_reg;
    assign break_det  = break_det_reg;
    assign overrun    = overrun_reg;
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Scoreboard bench for uart_rx_cfg: an 8N1 instance and an 8E1 instance, DIV = 1 (16 cycles/bit).
module tb_uart_rx_cfg;
    logic clk = 1'b0;
    logic rst = 1'b1;
    logic rx0 = 1'b1, rx1 = 1'b1;
    logic ready0 = 1'b1, ready1 = 1'b1;
    logic [7:0] data_out0, data_out1;
    logic valid0, valid1, perr0, perr1, ferr0, ferr1, brk0, brk1, ovr0, ovr1;

    always #5 clk = ~clk;

    uart_rx_cfg #(.CLK_FREQ(1843200), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(0),
                  .STOP_BITS(1), .OVERSAMPLE(16)) dut0 (
        .clk(clk), .rst(rst), .rx(rx0), .data_out(data_out0), .valid(valid0), .ready(ready0),
        .parity_err(perr0), .frame_err(ferr0), .break_det(brk0), .overrun(ovr0));

    uart_rx_cfg #(.CLK_FREQ(1843200), .BAUD_RATE(115200), .DATA_BITS(8), .PARITY(2),
                  .STOP_BITS(1), .OVERSAMPLE(16)) dut1 (
        .clk(clk), .rst(rst), .rx(rx1), .data_out(data_out1), .valid(valid1), .ready(ready1),
        .parity_err(perr1), .frame_err(ferr1), .break_det(brk1), .overrun(ovr1));

    typedef struct packed {
        logic [7:0] d;
        logic       pe;
        logic       fe;
    } exp_t;

    exp_t exp0_q[$];
    exp_t exp1_q[$];
    int n_checks = 0, n_pass = 0;
    int vcnt0 = 0, vcnt1 = 0;
    int brk_cnt0 = 0, brk_cnt1 = 0, ovr_cnt0 = 0, ovr_cnt1 = 0;
    logic brk0_prev = 1'b0, ovr0_prev = 1'b0;

    task automatic check(input string name, input int got, input int want);
        n_checks++;
        if (got == want) n_pass++;
        else $display("FAIL %s: got %0h expected %0h", name, got, want);
    endtask

    task automatic check_frame(input string tag, input exp_t e, input logic [7:0] d,
                               input logic pe, input logic fe);
        $display("%s frame: data=%02h perr=%0b ferr=%0b (want %02h %0b %0b)", tag, d, pe, fe, e.d, e.pe, e.fe);
        check({tag, "_data"}, int'(d), int'(e.d));
        check({tag, "_perr"}, int'(pe), int'(e.pe));
        check({tag, "_ferr"}, int'(fe), int'(e.fe));
    endtask

    // Monitors: pop the scoreboard whenever a character is accepted.
    always @(negedge clk) begin
        if (!rst && valid0 && ready0) begin
            vcnt0++;
            if (exp0_q.size() == 0) begin
                n_checks++;
                $display("FAIL dut0_unexpected_valid: got data=%02h expected no valid", data_out0);
            end else begin
                check_frame("dut0", exp0_q.pop_front(), data_out0, perr0, ferr0);
            end
        end
    end

    always @(negedge clk) begin
        if (!rst && valid1 && ready1) begin
            vcnt1++;
            if (exp1_q.size() == 0) begin
                n_checks++;
                $display("FAIL dut1_unexpected_valid: got data=%02h expected no valid", data_out1);
            end else begin
                check_frame("dut1", exp1_q.pop_front(), data_out1, perr1, ferr1);
            end
        end
    end

    always @(negedge clk) begin
        if (brk0) brk_cnt0++;
        if (ovr0) ovr_cnt0++;
        if (brk1) brk_cnt1++;
        if (ovr1) ovr_cnt1++;
        if (brk0 && ovr0) begin
            n_checks++;
            $display("FAIL pulse_overlap: got break_det=1 overrun=1 expected never both");
        end
        if ((brk0 && brk0_prev) || (ovr0 && ovr0_prev)) begin
            n_checks++;
            $display("FAIL pulse_width: got pulse longer than 1 cycle expected 1");
        end
        brk0_prev = brk0;
        ovr0_prev = ovr0;
    end

    task automatic set_line(input int which, input logic v);
        if (which == 0) rx0 = v;
        else rx1 = v;
    endtask

    task automatic drive_bit(input int which, input logic v, input logic flip);
        logic b;
        for (int i = 0; i < 16; i++) begin
            b = (flip && i == 9) ? ~v : v;
            set_line(which, b);
            @(negedge clk);
        end
    endtask

    task automatic send(input int which, input logic [7:0] d, input logic par_en,
                        input logic par, input logic stop_v, input int flip_idx);
        drive_bit(which, 1'b0, 1'b0);
        for (int i = 0; i < 8; i++) drive_bit(which, d[i], (i == flip_idx));
        if (par_en) drive_bit(which, par, 1'b0);
        drive_bit(which, stop_v, 1'b0);
        set_line(which, 1'b1);
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge clk);
    endtask

    function automatic exp_t mk(input logic [7:0] d, input logic pe, input logic fe);
        exp_t e;
        e.d = d; e.pe = pe; e.fe = fe;
        return e;
    endfunction

    initial begin
        int lat;
        int vb;
        @(negedge clk);
        idle(3);
        check("reset_valid", int'(valid0), 0);
        check("reset_data", int'(data_out0), 0);
        check("reset_flags", int'({perr0, ferr0, brk0, ovr0}), 0);
        rst = 1'b0;
        idle(20);

        // 8N1 clean, back-to-back, with latency measurement on the first frame
        exp0_q.push_back(mk(8'hA5, 1'b0, 1'b0));
        exp0_q.push_back(mk(8'h3C, 1'b0, 1'b0));
        lat = 0;
        fork
            send(0, 8'hA5, 1'b0, 1'b0, 1'b1, -1);
            begin
                while (!valid0 && lat < 400) begin
                    @(negedge clk);
                    lat++;
                end
            end
        join
        n_checks++;
        if (lat >= 155 && lat <= 158) n_pass++;
        else $display("FAIL latency: got %0d cycles expected 155..158", lat);
        send(0, 8'h3C, 1'b0, 1'b0, 1'b1, -1);
        idle(40);

        // Even parity: 0x0F has four ones, so parity bit 1 is an error, 0 is correct
        exp1_q.push_back(mk(8'h0F, 1'b1, 1'b0));
        send(1, 8'h0F, 1'b1, 1'b1, 1'b1, -1);
        idle(20);
        exp1_q.push_back(mk(8'h0F, 1'b0, 1'b0));
        send(1, 8'h0F, 1'b1, 1'b0, 1'b1, -1);
        idle(40);

        // Framing error then a clean frame
        exp0_q.push_back(mk(8'h55, 1'b0, 1'b1));
        send(0, 8'h55, 1'b0, 1'b0, 1'b0, -1);
        idle(48);
        exp0_q.push_back(mk(8'h12, 1'b0, 1'b0));
        send(0, 8'h12, 1'b0, 1'b0, 1'b1, -1);
        idle(40);

        // Break: 12 bit times low
        vb = vcnt0;
        rx0 = 1'b0;
        idle(192);
        rx0 = 1'b1;
        idle(40);
        check("break_count", brk_cnt0, 1);
        check("break_no_valid", vcnt0, vb);
        exp0_q.push_back(mk(8'h81, 1'b0, 1'b0));
        send(0, 8'h81, 1'b0, 1'b0, 1'b1, -1);
        idle(40);

        // Glitch on idle line
        vb = vcnt0;
        rx0 = 1'b0;
        idle(4);
        rx0 = 1'b1;
        idle(48);
        check("glitch_no_valid", vcnt0, vb);

        // Single inverted sample inside data bit 3 (a 1) must be outvoted
        exp0_q.push_back(mk(8'h5A, 1'b0, 1'b0));
        send(0, 8'h5A, 1'b0, 1'b0, 1'b1, 3);
        idle(40);

        // Overrun with consumer stalled
        ready0 = 1'b0;
        exp0_q.push_back(mk(8'h11, 1'b0, 1'b0));
        send(0, 8'h11, 1'b0, 1'b0, 1'b1, -1);
        send(0, 8'h22, 1'b0, 1'b0, 1'b1, -1);
        idle(20);
        check("overrun_count", ovr_cnt0, 1);
        check("overrun_held_data", int'(data_out0), 8'h11);
        check("overrun_valid_held", int'(valid0), 1);
        @(posedge clk);
        #1 ready0 = 1'b1;
        @(negedge clk);
        idle(20);

        // Reset in the middle of 0x77
        drive_bit(0, 1'b0, 1'b0);
        drive_bit(0, 1'b1, 1'b0);
        drive_bit(0, 1'b1, 1'b0);
        drive_bit(0, 1'b1, 1'b0);
        rst = 1'b1;
        rx0 = 1'b1;
        idle(3);
        check("midrst_valid", int'(valid0), 0);
        check("midrst_data", int'(data_out0), 0);
        check("midrst_flags", int'({perr0, ferr0, brk0, ovr0}), 0);
        rst = 1'b0;
        idle(40);
        exp0_q.push_back(mk(8'h99, 1'b0, 1'b0));
        send(0, 8'h99, 1'b0, 1'b0, 1'b1, -1);
        idle(60);

        check("dut0_pending", exp0_q.size(), 0);
        check("dut1_pending", exp1_q.size(), 0);
        check("dut1_break_count", brk_cnt1, 0);
        check("dut1_overrun_count", ovr_cnt1, 0);
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule

// File: doc/uart_rx_cfg.md
# uart_rx_cfg

Parametrised UART receiver for the host link, replacing the fixed 8N1 receiver on the FPGA side. Data width, parity mode, stop-bit count and oversampling ratio are set by parameters. Each bit is sampled three times and decided by majority vote. Parity, framing, break and overrun conditions are reported alongside each frame. Received characters are held in a one-entry output register with a valid/ready handshake toward the command parser.

## Interface
- CLK_FREQ, 50_000_000: system clock frequency in Hz.
- BAUD_RATE, 115200: line rate in baud.
- DATA_BITS, 8: data bits per frame, legal range 5..9.
- PARITY, 0: 0 = none, 1 = odd, 2 = even.
- STOP_BITS, 1: 1 or 2.
- OVERSAMPLE, 16: ticks per bit, even, minimum 8.

- clk  in  1  system clock; one clock domain only.
- rst  in  1  reset, synchronous and active-high.
- rx  in  1  serial line, idle high, asynchronous to clk.
- data_out  out  DATA_BITS  received character, LSB = first bit on the line.
- valid  out  1  data_out and flags are valid; held until accepted.
- ready  in  1  consumer accepts the character when valid && ready.
- parity_err  out  1  parity mismatch for the held character; always 0 when PARITY = 0.
- frame_err  out  1  at least one stop bit sampled low for the held character.
- break_det  out  1  one-cycle pulse when a break is detected.
- overrun  out  1  one-cycle pulse when a completed frame is dropped.

## Operation
- Input synchroniser: 2-FF synchroniser on rx, both stages reset to 1. All logic below uses the synchronised value rxs.
- Tick generator:
  - DIV = CLK_FREQ / (BAUD_RATE*OVERSAMPLE), integer division.
  - Elaboration fails if DIV < 1, OVERSAMPLE is odd or below 8, DATA_BITS is outside 5..9, or STOP_BITS is not 1 or 2.
  - Divider counter runs 0..DIV-1; tick fires at DIV-1.
  - Sample counter s runs 0..OVERSAMPLE-1 per bit.
  - Both counters clear when START is entered, so bit timing is phase-aligned to the start edge.
- Majority sampling:
  - Let M = OVERSAMPLE/2. Samples are taken at ticks s = M-1, M, M+1.
  - The bit value is the majority of the three samples, decided at tick s = M+1.
  - The bit period ends at tick s = OVERSAMPLE-1.
- States: IDLE, START, DATA, PARITY, STOP, BREAK.
- IDLE: on rxs = 0, enter START.
- START:
  - If the majority value is 1, the start bit was a glitch: return to IDLE. Nothing is reported.
  - Otherwise go to DATA at the end of the bit.
- DATA: shift in DATA_BITS bits, LSB first. After the last bit, go to PARITY if PARITY != 0, else STOP.
- PARITY: the decided bit is compared against the XOR of the data bits. Odd mode expects the total count of ones to be odd; even mode expects it to be even.
- STOP:
  - Each stop bit is decided by majority vote; any 0 sets the frame error.
  - The frame completes at the decision tick (s = M+1) of the last stop bit, not at the bit end, so the receiver can resync on a back-to-back start bit.
  - If all data bits, the parity bit (if present) and the first stop bit are 0, the frame is a break: pulse break_det, do not deliver data, go to BREAK.
  - Otherwise deliver the frame and go to IDLE.
- BREAK: stay until rxs = 1, then go to IDLE.
- Delivery:
  - If valid = 0, or valid && ready in the same cycle, load data_out, parity_err and frame_err, and set valid = 1.
  - Otherwise the new frame is discarded, overrun pulses, and the held character and flags are left unchanged.
- Handshake:
  - valid, data_out and the flags stay stable until valid && ready.
  - When valid && ready occurs with no load in that cycle, valid drops the next cycle.
- A frame with frame_err = 1 is still delivered, with data as sampled.

## Timing
- Reset values: valid, parity_err, frame_err, break_det and overrun are 0; data_out is 0; state is IDLE; all counters are 0.
- Reset mid-frame: the partial frame is discarded and the held character is cleared. The first start bit after rst deasserts is received normally.
- Latency from an rx falling edge to valid rising:
  - Ideal value: 2 sync cycles + (1 + DATA_BITS + (PARITY != 0) + STOP_BITS - 1) bit times + (M+1) ticks + 1 cycle.
  - Tolerance: ±1 tick.
- valid rises exactly 1 cycle after the stop decision tick.
- break_det and overrun are each exactly 1 cycle wide and are never asserted together.
- Simultaneous load and accept (valid && ready at the completion cycle) gives no overrun: the new data replaces the old with valid staying at 1.
- The receiver tolerates ±3 % baud mismatch at OVERSAMPLE = 16.

## Test plan
All scenarios use CLK_FREQ = 1_843_200, BAUD_RATE = 115200, OVERSAMPLE = 16 (DIV = 1), with ready held high unless stated.
- 8N1 clean: send 0xA5 -> valid with data_out = 0xA5, parity_err = 0, frame_err = 0; then send 0x3C back-to-back -> 0x3C delivered.
- PARITY = 2: send 0x0F with parity bit 1 -> parity_err = 1, data_out = 0x0F. Send again with parity bit 0 -> parity_err = 0.
- Framing: send 0x55 with stop bit driven 0 -> valid with data_out = 0x55 and frame_err = 1. The next frame, 0x12, is received cleanly.
- Break: hold rx low for 12 bit times, then release -> a single break_det pulse and no valid. A following 0x81 is received with no flags.
- Glitch and majority:
  - A 4-cycle low pulse on an idle line -> no valid.
  - A single-cycle inverted sample at s = M inside a data bit -> no change to the decided bit.
- Overrun and reset:
  - With ready = 0, send 0x11 then 0x22 -> data_out stays 0x11 and one overrun pulse occurs.
  - Assert rst mid-way through a frame of 0x77 -> all outputs 0 and no valid. A following 0x99 is received correctly.
